// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU hookup, branch/jump resolution and a one-deep output register
// with a single-cycle fetch redirect that squashes the wrong-path instruction behind it.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [4:0]  in_rd,
    input  logic [3:0]  in_alu_func,
    input  logic        in_sel_a,
    input  logic        in_sel_b,
    input  logic [1:0]  in_kind,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_out,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    localparam logic [1:0] KIND_ALU = 2'd0;
    localparam logic [1:0] KIND_BR  = 2'd1;
    localparam logic [1:0] KIND_JALR = 2'd3;

    logic        out_valid_q, redirect_valid_q;
    logic [31:0] out_result_q, out_store_data_q, redirect_pc_q;
    logic [4:0]  out_rd_q;
    logic [31:0] fwd_rs1, fwd_rs2, pc_plus4, target, result;
    logic        taken, take;

    // The output register is the younger producer, so it wins over writeback.
    assign fwd_rs1 = (in_rs1 == 5'd0) ? 32'd0 : (out_valid_q && out_rd_q == in_rs1) ? out_result_q :
                     (wb_valid && wb_rd == in_rs1) ? wb_result : in_rs1_val;
    assign fwd_rs2 = (in_rs2 == 5'd0) ? 32'd0 : (out_valid_q && out_rd_q == in_rs2) ? out_result_q :
                     (wb_valid && wb_rd == in_rs2) ? wb_result : in_rs2_val;

    assign alu_in1  = (in_kind == KIND_ALU && in_sel_a) ? in_pc : fwd_rs1;
    assign alu_in2  = (in_kind == KIND_ALU && in_sel_b) ? in_imm : fwd_rs2;
    assign alu_func = in_alu_func;

    assign pc_plus4 = in_pc + 32'd4;
    assign target   = (in_kind == KIND_JALR) ? ((fwd_rs1 + in_imm) & ~32'd1) : in_pc + in_imm;
    assign taken    = (in_kind == KIND_BR) ? alu_out[0] : in_kind[1];
    assign result   = (in_kind == KIND_ALU) ? alu_out : (in_kind == KIND_BR) ? 32'd0 : pc_plus4;

    assign in_ready = !out_valid_q || out_ready || redirect_valid_q;
    assign take     = in_valid && in_ready && !redirect_valid_q;

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_store_data = out_store_data_q;
    assign out_rd         = out_rd_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            out_result_q     <= '0;
            out_store_data_q <= '0;
            out_rd_q         <= '0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= take && taken;
            if (take && taken)
                redirect_pc_q <= target;
            if (take) begin
                out_valid_q      <= 1'b1;
                out_result_q     <= result;
                out_store_data_q <= fwd_rs2;
                out_rd_q         <= (in_kind == KIND_BR) ? 5'd0 : in_rd;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vector table, hand sequences for stall/redirect/reset corners,
// and randomized traffic checked against a behavioural model of the stage.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_sel_a, in_sel_b, wb_valid, out_valid, out_ready;
    logic        redirect_valid;
    logic [31:0] in_pc, in_imm, in_rs1_val, in_rs2_val, alu_in1, alu_in2, alu_out, wb_result;
    logic [31:0] out_result, out_store_data, redirect_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd, out_rd;
    logic [3:0]  in_alu_func, alu_func;
    logic [1:0]  in_kind;

    int checks = 0;
    int errors = 0;

    // Behavioural view of the stage: one result slot plus a one-shot redirect.
    logic        m_ov, m_rv;
    logic [31:0] m_res, m_sd, m_rpc;
    logic [4:0]  m_rd;

    execute_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val),
        .in_rs2_val(in_rs2_val), .in_rd(in_rd), .in_alu_func(in_alu_func), .in_sel_a(in_sel_a),
        .in_sel_b(in_sel_b), .in_kind(in_kind), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_func(alu_func), .alu_out(alu_out), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_result(wb_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
        if (idx == 5'd0) return 32'd0;
        if (m_ov && m_rd == idx) return m_res;
        if (wb_valid && wb_rd == idx) return wb_result;
        return v;
    endfunction

    // Inputs are already applied; checks combinational outputs, clocks once, checks registers.
    task automatic cycle();
        logic        e_ready, acc, tk, n_ov, n_rv;
        logic [31:0] f1, f2, tgt, res, n_res, n_sd, n_rpc;
        logic [4:0]  n_rd;
        @(negedge clk);
        e_ready = !m_ov || out_ready || m_rv;
        f1 = fwd(in_rs1, in_rs1_val);
        f2 = fwd(in_rs2, in_rs2_val);
        check("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
        check("alu_in1", alu_in1, (in_kind == 2'd0 && in_sel_a) ? in_pc : f1);
        check("alu_in2", alu_in2, (in_kind == 2'd0 && in_sel_b) ? in_imm : f2);
        check("alu_func", {28'd0, alu_func}, {28'd0, in_alu_func});
        case (in_kind)
            2'd0: begin res = alu_out; tk = 1'b0; tgt = 32'd0; end
            2'd1: begin res = 32'd0; tk = alu_out[0]; tgt = in_pc + in_imm; end
            2'd2: begin res = in_pc + 32'd4; tk = 1'b1; tgt = in_pc + in_imm; end
            default: begin res = in_pc + 32'd4; tk = 1'b1; tgt = (f1 + in_imm) & 32'hFFFF_FFFE; end
        endcase
        n_ov = m_ov; n_res = m_res; n_sd = m_sd; n_rd = m_rd; n_rpc = m_rpc;
        acc = in_valid && e_ready && !m_rv;
        n_rv = acc && tk;
        if (n_rv) n_rpc = tgt;
        if (acc) begin
            n_ov = 1'b1; n_res = res; n_sd = f2; n_rd = (in_kind == 2'd1) ? 5'd0 : in_rd;
        end else if (out_ready) n_ov = 1'b0;
        if (reset) begin
            n_ov = 0; n_rv = 0; n_res = 0; n_sd = 0; n_rd = 0; n_rpc = 0;
        end
        @(posedge clk);
        #1;
        m_ov = n_ov; m_rv = n_rv; m_res = n_res; m_sd = n_sd; m_rd = n_rd; m_rpc = n_rpc;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        check("out_result", out_result, m_res);
        check("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        check("out_store_data", out_store_data, m_sd);
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
        check("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic instr(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] r1, input logic [31:0] v1, input logic [4:0] r2,
                         input logic [31:0] v2, input logic [4:0] rd, input logic [31:0] alu);
        in_valid = 1'b1; in_kind = k; in_pc = pc; in_imm = imm; in_rs1 = r1; in_rs1_val = v1;
        in_rs2 = r2; in_rs2_val = v2; in_rd = rd; alu_out = alu; in_sel_a = 1'b0; in_sel_b = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc, imm, r1, r2;
        logic [4:0]  rd;
        logic        sa, sb;
        logic [31:0] alu, eres;
        logic [4:0]  erd;
        logic        erv;
        logic [31:0] erpc;
    } vec_t;

    vec_t vt[7];
    logic [31:0] held;

    initial begin
        vt[0] = '{2'd0, 32'h0, 32'h0, 32'd5, 32'd7, 5'd4, 1'b0, 1'b0, 32'd12, 32'd12, 5'd4, 1'b0, 32'h0};
        vt[1] = '{2'd1, 32'h100, 32'h20, 32'd1, 32'd1, 5'd5, 1'b0, 1'b0, 32'd1, 32'd0, 5'd0, 1'b1, 32'h120};
        vt[2] = '{2'd1, 32'h100, 32'h20, 32'd1, 32'd2, 5'd5, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h0};
        vt[3] = '{2'd2, 32'h300, 32'hFFFF_FFF0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 32'd0, 32'h304, 5'd1, 1'b1, 32'h2F0};
        vt[4] = '{2'd3, 32'h200, 32'h4, 32'h1003, 32'd0, 5'd9, 1'b0, 1'b0, 32'd0, 32'h204, 5'd9, 1'b1, 32'h1006};
        vt[5] = '{2'd2, 32'hFFFF_FFFC, 32'h8, 32'd0, 32'd0, 5'd2, 1'b0, 1'b0, 32'd0, 32'h0, 5'd2, 1'b1, 32'h4};
        vt[6] = '{2'd0, 32'h40, 32'h8, 32'd3, 32'd4, 5'd6, 1'b1, 1'b1, 32'hDEAD, 32'hDEAD, 5'd6, 1'b0, 32'h0};

        reset = 1'b1; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_result = '0; in_alu_func = 4'h3;
        instr(2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_ov = 0; m_rv = 0; m_res = 0; m_sd = 0; m_rd = 0; m_rpc = 0;
        reset = 1'b0;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vt[i]) begin
            instr(vt[i].kind, vt[i].pc, vt[i].imm, 5'd1, vt[i].r1, 5'd2, vt[i].r2, vt[i].rd, vt[i].alu);
            in_sel_a = vt[i].sa; in_sel_b = vt[i].sb;
            cycle();
            check($sformatf("vec%0d result", i), out_result, vt[i].eres);
            check($sformatf("vec%0d rd", i), {27'd0, out_rd}, {27'd0, vt[i].erd});
            check($sformatf("vec%0d redirect", i), {31'd0, redirect_valid}, {31'd0, vt[i].erv});
            if (vt[i].erv) check($sformatf("vec%0d target", i), redirect_pc, vt[i].erpc);
            in_valid = 1'b0;
            cycle();
        end

        // Back-to-back forwarding: output register beats a conflicting writeback.
        instr(2'd0, 32'h0, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'h10);
        cycle();
        instr(2'd0, 32'h0, 32'h0, 5'd3, 32'd0, 5'd0, 32'h55, 5'd0, 32'h0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_result = 32'h99;
        #1;
        check("fwd out_reg wins", alu_in1, 32'h10);
        check("fwd x0 is zero", alu_in2, 32'h0);
        cycle();
        in_valid = 1'b0;
        cycle();
        in_valid = 1'b1;
        #1;
        check("fwd from wb", alu_in1, 32'h99);
        cycle();
        wb_valid = 1'b0; in_valid = 1'b0;
        cycle();

        // Taken branch squashes the very next instruction.
        instr(2'd1, 32'h100, 32'h20, 5'd1, 32'd0, 5'd2, 32'd0, 5'd0, 32'd1);
        cycle();
        check("beq redirect", {31'd0, redirect_valid}, 32'd1);
        check("beq target", redirect_pc, 32'h120);
        instr(2'd0, 32'h124, 32'h0, 5'd1, 32'd0, 5'd2, 32'd0, 5'd7, 32'h55);
        cycle();
        check("squash no redirect", {31'd0, redirect_valid}, 32'd0);
        check("squash no output", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        cycle();

        // Backpressure: three stalled cycles, then acceptance.
        instr(2'd0, 32'h0, 32'h0, 5'd1, 32'd0, 5'd2, 32'd0, 5'd8, 32'hAAAA);
        cycle();
        out_ready = 1'b0;
        instr(2'd0, 32'h0, 32'h0, 5'd1, 32'd0, 5'd2, 32'd0, 5'd9, 32'hBBBB);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall in_ready", {31'd0, in_ready}, 32'd0);
            cycle();
            check("stall hold", out_result, 32'hAAAA);
        end
        out_ready = 1'b1;
        cycle();
        check("stall release", out_result, 32'hBBBB);

        // Stall while redirecting: held jal result kept, wrong-path instruction dropped.
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        instr(2'd2, 32'h500, 32'h40, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd0);
        cycle();
        held = out_result;
        check("jal held result", held, 32'h504);
        instr(2'd0, 32'h504, 32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 32'h77);
        cycle();
        check("stall+redirect hold", out_result, 32'h504);
        check("stall+redirect drop", {31'd0, redirect_valid}, 32'd0);

        // Reset with both a held result and a live redirect.
        instr(2'd0, 32'h0, 32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd2, 32'h5);
        out_ready = 1'b1;
        cycle();
        instr(2'd2, 32'h600, 32'h10, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd0);
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst valid", {31'd0, out_valid}, 32'd0);
        check("rst redirect", {31'd0, redirect_valid}, 32'd0);
        check("rst pc", redirect_pc, 32'd0);
        check("rst ready", {31'd0, in_ready}, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_kind = 2'($urandom);
            in_pc = $urandom; in_imm = $urandom;
            in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3));
            in_rs1_val = $urandom; in_rs2_val = $urandom;
            in_rd = 5'($urandom_range(0, 3));
            in_alu_func = 4'($urandom);
            in_sel_a = 1'($urandom); in_sel_b = 1'($urandom);
            alu_out = $urandom;
            wb_valid = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_result = $urandom;
            out_ready = $urandom_range(0, 2) != 0;
            reset = $urandom_range(0, 63) == 0;
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, register indices 5 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  decode stage presents an instruction.
REQ-005 in_ready  out  1  stage accepts the presented instruction this cycle.
REQ-006 in_pc, in_imm  in  32 each  instruction address; sign-extended immediate.
REQ-007 in_rs1, in_rs2  in  5 each  source register indices.
REQ-008 in_rs1_val, in_rs2_val  in  32 each  register-file read values.
REQ-009 in_rd  in  5  destination index; 0 means no write.
REQ-010 in_alu_func  in  4  ALU function code, passed through unchanged.
REQ-011 in_sel_a, in_sel_b  in  1 each  operand A: 0=rs1, 1=pc; operand B: 0=rs2, 1=imm.
REQ-012 in_kind  in  2  0=ALU op, 1=conditional branch, 2=jal, 3=jalr.
REQ-013 alu_in1, alu_in2  out  32 each  combinational operands to the ALU.
REQ-014 alu_func  out  4  combinational function code to the ALU.
REQ-015 alu_out  in  32  combinational ALU result.
REQ-016 wb_valid, wb_rd, wb_result  in  1/5/32  writeback-stage forwarding source.
REQ-017 out_valid  out  1  registered result valid toward memory stage.
REQ-018 out_ready  in  1  memory stage accepts the result.
REQ-019 out_result, out_store_data  out  32 each  registered result; forwarded rs2 value.
REQ-020 out_rd  out  5  registered destination index.
REQ-021 redirect_valid, redirect_pc  out  1/32  registered fetch redirect.

Function
REQ-022 in_ready SHALL equal (!out_valid || out_ready || redirect_valid); an instruction is accepted on in_valid && in_ready.
REQ-023 Forwarded rs1/rs2 SHALL take priority: output register (out_valid, out_rd == index, index != 0) > writeback (wb_valid, wb_rd == index, index != 0) > in_rsX_val; index 0 SHALL always yield 0.
REQ-024 kind 0: alu_in1 = sel_a ? pc : fwd_rs1; alu_in2 = sel_b ? imm : fwd_rs2; accepted result = alu_out.
REQ-025 kind 1: alu_in1 = fwd_rs1, alu_in2 = fwd_rs2; taken = alu_out[0]; target = pc + imm; result = 0; out_rd SHALL be 0.
REQ-026 kind 2: result = pc + 4; target = pc + imm; always taken.
REQ-027 kind 3: result = pc + 4; target = (fwd_rs1 + imm) with bit 0 cleared; always taken.
REQ-028 All additions SHALL be modulo 2^32; pc + 4 wraps at 0xFFFFFFFC to 0x00000000.
REQ-029 On acceptance, out_valid, out_result, out_rd, out_store_data SHALL load on the next edge (latency 1 cycle).
REQ-030 When out_valid && !out_ready and nothing is accepted, output registers SHALL hold.
REQ-031 When out_valid && out_ready and nothing is accepted, out_valid SHALL clear next cycle.
REQ-032 Accepting a taken branch/jump SHALL set redirect_valid and redirect_pc = target for exactly one cycle, even if out_ready is low.
REQ-033 While redirect_valid is high, any in_valid instruction SHALL be consumed and discarded: no output-register update, no redirect.
REQ-034 Stall + redirect: if out_valid && !out_ready while redirect_valid, the held output SHALL be preserved and the wrong-path instruction still discarded.
REQ-035 ALU outputs SHALL be driven combinationally from the current in_* inputs every cycle, independent of in_valid.

Reset
REQ-036 While reset is high at an edge: out_valid = 0, redirect_valid = 0, out_result = 0, out_rd = 0, out_store_data = 0, redirect_pc = 0.
REQ-037 Reset SHALL abandon any held or in-flight result; in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-038 ADD: rs1_val=5, rs2_val=7, sel 0/0, func ADD, alu_out=12 -> next cycle out_valid=1, out_result=12, out_rd as given.
REQ-039 Back-to-back forward: instr A rd=3 result 0x10; instr B rs1=3, rs1_val=0 -> alu_in1=0x10 while A is in output register; wb_rd=3 with other value loses.
REQ-040 BEQ taken: pc=0x100, imm=0x20, alu_out=1 -> redirect_valid=1 for one cycle, redirect_pc=0x120; next in_valid instruction discarded.
REQ-041 JALR: pc=0x200, rs1=0x1003, imm=4 -> out_result=0x204, redirect_pc=0x1006.
REQ-042 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next instruction accepted.
REQ-043 Reset asserted while out_valid=1 and redirect_valid=1 -> both 0 next cycle, all outputs 0.
